ccmp_tx_feeder: RTL and testbench
=================================

Name: ccmp_tx_feeder

Overview:
- Transmit-side writer for the CCMP engine.
- Takes one protected frame as a byte stream from the TX path: MAC header bytes, then plaintext payload bytes.
- Starts a CCMP session, then pushes the bytes into the CCMP input register one byte per write. It stalls at every 16-byte block boundary until the engine has consumed the block.
- Signals end of payload, then waits for the engine's last output byte before returning to idle.

Parameters:
- BLK_BYTES, 16, bytes per CCMP input block
- LEN_W, 16, payload length counter width
- HDR_MIN, 24, smallest legal header length in bytes
- HDR_MAX, 32, largest legal header length in bytes
- DRAIN_TIMEOUT, 1023, max cycles in DRAIN before abort

Ports:
- macCoreClk  in  1  clock
- pRst  in  1  reset, asynchronous, active-high
- startFrame_p  in  1  one-cycle request to protect a frame; hdrLen and payloadLen are sampled in the same cycle
- hdrLen  in  6  MAC header length in bytes
- payloadLen  in  LEN_W  plaintext payload length in bytes
- srcData  in  8  frame byte from the TX path
- srcValid  in  1  srcData is valid
- srcLast  in  1  marks the last payload byte
- srcReady  out  1  feeder accepts srcData this cycle
- txError_p  in  1  abort pulse
- ccmp_isIdle  in  1  CCMP engine is idle
- ccmpRegFull  in  1  CCMP input register is full (registered flag)
- ccmpOutLast_p  in  1  engine has emitted its last output byte
- initCCMP_p  out  1  session init pulse
- wrCCMPEn_p  out  1  byte write strobe
- plainText  out  8  byte being written
- payloadEnd_p  out  1  end-of-payload pulse
- busy  out  1  feeder is not IDLE
- lenError_p  out  1  length violation pulse
- timeout_p  out  1  DRAIN timeout pulse

Behaviour:
- Reset: state=IDLE. All counters are 0 and blkHold=0. Every output is 0 during reset (plainText=8'h00).
- States: IDLE, WAIT_IDLE, INIT, HDR, PAYLOAD, END, DRAIN.
- IDLE:
  - startFrame_p latches hdrLen and payloadLen.
  - If hdrLen < HDR_MIN or hdrLen > HDR_MAX: lenError_p for 1 cycle, stay IDLE.
  - Otherwise go to WAIT_IDLE.
  - startFrame_p outside IDLE is ignored.
- WAIT_IDLE: go to INIT on the first cycle ccmp_isIdle=1.
- INIT: initCCMP_p=1 for exactly this cycle, then go to HDR. hdrCnt=0, blkCnt=0.
- Write rule (HDR and PAYLOAD only):
  - srcReady = !ccmpRegFull && !blkHold.
  - wrCCMPEn_p = srcValid && srcReady.
  - plainText = srcData (combinational pass-through; 0 when not writing).
- Block hold:
  - blkHold is set on any write that is block byte BLK_BYTES-1, the last header byte, or the last payload byte.
  - blkHold is cleared on the first cycle ccmpRegFull=1 is observed after it was set.
  - Writes then resume once ccmpRegFull=0.
  - blkCnt wraps 15 -> 0 and resets to 0 at the HDR->PAYLOAD transition.
- HDR:
  - Counts hdrLen writes.
  - On the last header write: go to PAYLOAD if payloadLen != 0, else go to END.
  - srcLast during HDR: lenError_p, go to IDLE.
- PAYLOAD:
  - Counts payloadLen writes.
  - The last write must carry srcLast=1; then go to END.
  - srcLast on an earlier write, or srcLast=0 on the final write: lenError_p, go to IDLE, no payloadEnd_p.
- END: payloadEnd_p=1 for this single cycle, then go to DRAIN. This is the cycle after the last payload write, or after the last header write when payloadLen=0.
- DRAIN:
  - Wait for ccmpOutLast_p, then go to IDLE.
  - A cycle counter hitting DRAIN_TIMEOUT raises timeout_p and goes to IDLE.
- txError_p:
  - In any non-IDLE state: go to IDLE next cycle, clear blkHold and counters. srcReady and wrCCMPEn_p are forced 0 in that cycle.
  - Takes priority over every other event in the same cycle, including the last write and ccmpOutLast_p.
- busy = (state != IDLE).
- Pulses (initCCMP_p, payloadEnd_p, lenError_p, timeout_p) are registered, mutually exclusive, and 1 cycle wide.

Decomposition:
- Shared package ccmp_pkg:
  - state enum
  - BLK_BYTES
  - HDR_MIN and HDR_MAX
  - length type of LEN_W bits
- One sub-module: ccmp_feed_blkctl. It holds blkCnt, the blkHold set/clear logic and srcReady generation.
- The FSM and the length counters stay in the top level.

Test Plan:
- Basic frame: hdrLen=24, payloadLen=20, ccmp_isIdle=1, srcValid always 1, engine model raises ccmpRegFull 1 cycle after each hold for 2 cycles. Expect:
  - initCCMP_p once
  - 44 wrCCMPEn_p with bytes in order
  - holds after header bytes 16 and 24 and payload bytes 16 and 20
  - payloadEnd_p 1 cycle after the 44th write
  - busy drops the cycle after ccmpOutLast_p
- Zero payload: hdrLen=30, payloadLen=0 -> 30 writes, payloadEnd_p, DRAIN, IDLE; srcReady=0 in PAYLOAD is never observed.
- Length errors:
  - srcLast on payload byte 5 of 10 -> lenError_p, IDLE, no payloadEnd_p.
  - hdrLen=40 at start -> lenError_p, busy stays 0.
- Abort and wait: txError_p in the same cycle as the final payload write -> no payloadEnd_p, IDLE next cycle. In a separate case, startFrame_p with ccmp_isIdle=0 for 5 cycles -> initCCMP_p the cycle after ccmp_isIdle rises.
- Backpressure and timeout: srcValid toggled randomly and ccmpRegFull held high for 20 cycles -> byte order preserved, no write while ccmpRegFull=1. Separately, ccmpOutLast_p never asserted -> timeout_p after 1023 DRAIN cycles.

Source files
------------

// File: rtl/ccmp_pkg.sv
// Shared types and constants for the CCMP transmit feeder.
// Imported by the feeder top, its block controller and the bench.
package ccmp_pkg;

    localparam int BLK_BYTES = 16;
    localparam int LEN_W     = 16;
    localparam int HDR_MIN   = 24;
    localparam int HDR_MAX   = 32;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        INIT,
        HDR,
        PAYLOAD,
        END,
        DRAIN
    } feedState_e;

    function automatic logic hdrLenOk(input logic [5:0] len);
        return (len >= 6'(HDR_MIN)) && (len <= 6'(HDR_MAX));
    endfunction

endpackage

// File: rtl/ccmp_tx_feeder_if.sv
// Byte stream from the TX path into the CCMP feeder.
// The master drives data; the slave (feeder) answers with srcReady.
interface ccmp_tx_feeder_if;

    logic [7:0] srcData;
    logic       srcValid;
    logic       srcLast;
    logic       srcReady;

    modport master (
        output srcData,
        output srcValid,
        output srcLast,
        input  srcReady
    );

    modport slave (
        input  srcData,
        input  srcValid,
        input  srcLast,
        output srcReady
    );

endinterface

// File: rtl/ccmp_feed_blkctl.sv
// Block-boundary control for the feeder: position inside the
// current 16-byte block, the hold flag and srcReady.
module ccmp_feed_blkctl
    import ccmp_pkg::*;
(
    input  logic macCoreClk,
    input  logic pRst,
    input  logic wrWindow,
    input  logic ccmpRegFull,
    input  logic txError_p,
    input  logic srcValid,
    input  logic lastByte,
    input  logic blkRestart,
    input  logic clr,
    output logic srcReady,
    output logic wrFire
);

    localparam int CW = $clog2(BLK_BYTES);

    logic [CW-1:0] blkCnt;
    logic          blkHold;
    logic          blkEnd;

    assign srcReady = wrWindow && !ccmpRegFull && !blkHold && !txError_p;
    assign wrFire   = srcReady && srcValid;
    assign blkEnd   = (blkCnt == CW'(BLK_BYTES - 1));

    // Hold after a block closes until the engine shows it took the block.
    always_ff @(posedge macCoreClk or posedge pRst) begin
        if (pRst) begin
            blkCnt  <= '0;
            blkHold <= 1'b0;
        end else if (clr) begin
            blkCnt  <= '0;
            blkHold <= 1'b0;
        end else begin
            if (blkRestart) begin
                blkCnt <= '0;
            end else if (wrFire) begin
                blkCnt <= blkCnt + CW'(1);
            end
            if (wrFire && (blkEnd || lastByte)) begin
                blkHold <= 1'b1;
            end else if (blkHold && ccmpRegFull) begin
                blkHold <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ccmp_tx_feeder.sv
// Transmit-side writer for the CCMP engine: header and payload bytes
// are pushed one per write, pausing at every block boundary.
module ccmp_tx_feeder
    import ccmp_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 1023
) (
    input  logic              macCoreClk,
    input  logic              pRst,
    input  logic              startFrame_p,
    input  logic [5:0]        hdrLen,
    input  len_t              payloadLen,
    ccmp_tx_feeder_if.slave   src,
    input  logic              txError_p,
    input  logic              ccmp_isIdle,
    input  logic              ccmpRegFull,
    input  logic              ccmpOutLast_p,
    output logic              initCCMP_p,
    output logic              wrCCMPEn_p,
    output logic [7:0]        plainText,
    output logic              payloadEnd_p,
    output logic              busy,
    output logic              lenError_p,
    output logic              timeout_p
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

    feedState_e     state;
    logic [5:0]     hdrLenQ;
    logic [5:0]     hdrCnt;
    len_t           payLenQ;
    len_t           payCnt;
    logic [DW-1:0]  drainCnt;

    logic wrFire;
    logic wrWindow;
    logic hdrLast;
    logic payLast;
    logic lastByte;
    logic abort;
    logic lenErr;
    logic blkRestart;
    logic clr;

    assign wrWindow   = (state == HDR) || (state == PAYLOAD);
    assign hdrLast    = (hdrCnt == hdrLenQ - 6'd1);
    assign payLast    = (payCnt == payLenQ - len_t'(1));
    assign lastByte   = (state == HDR) ? hdrLast : payLast;
    assign abort      = txError_p && (state != IDLE);
    assign lenErr     = wrFire &&
                        (((state == HDR) && src.srcLast) ||
                         ((state == PAYLOAD) && (src.srcLast != payLast)));
    assign blkRestart = (state == HDR) && wrFire && hdrLast;
    assign clr        = abort || lenErr || (state == INIT);

    assign wrCCMPEn_p = wrFire;
    assign plainText  = wrFire ? src.srcData : 8'h00;
    assign busy       = (state != IDLE);

    ccmp_feed_blkctl u_blkctl (
        .macCoreClk  (macCoreClk),
        .pRst        (pRst),
        .wrWindow    (wrWindow),
        .ccmpRegFull (ccmpRegFull),
        .txError_p   (txError_p),
        .srcValid    (src.srcValid),
        .lastByte    (lastByte),
        .blkRestart  (blkRestart),
        .clr         (clr),
        .srcReady    (src.srcReady),
        .wrFire      (wrFire)
    );

    always_ff @(posedge macCoreClk or posedge pRst) begin
        if (pRst) begin
            state        <= IDLE;
            hdrLenQ      <= '0;
            payLenQ      <= '0;
            hdrCnt       <= '0;
            payCnt       <= '0;
            drainCnt     <= '0;
            initCCMP_p   <= 1'b0;
            payloadEnd_p <= 1'b0;
            lenError_p   <= 1'b0;
            timeout_p    <= 1'b0;
        end else begin
            initCCMP_p   <= 1'b0;
            payloadEnd_p <= 1'b0;
            lenError_p   <= 1'b0;
            timeout_p    <= 1'b0;
            // An abort outranks whatever else this cycle would have done.
            if (abort) begin
                state    <= IDLE;
                hdrCnt   <= '0;
                payCnt   <= '0;
                drainCnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (startFrame_p) begin
                            hdrLenQ <= hdrLen;
                            payLenQ <= payloadLen;
                            if (hdrLenOk(hdrLen)) begin
                                state <= WAIT_IDLE;
                            end else begin
                                lenError_p <= 1'b1;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (ccmp_isIdle) begin
                            state      <= INIT;
                            initCCMP_p <= 1'b1;
                        end
                    end
                    INIT: begin
                        state  <= HDR;
                        hdrCnt <= '0;
                        payCnt <= '0;
                    end
                    HDR: begin
                        if (lenErr) begin
                            state      <= IDLE;
                            lenError_p <= 1'b1;
                        end else if (wrFire) begin
                            hdrCnt <= hdrCnt + 6'd1;
                            if (hdrLast) begin
                                if (payLenQ != '0) begin
                                    state <= PAYLOAD;
                                end else begin
                                    state        <= END;
                                    payloadEnd_p <= 1'b1;
                                end
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (lenErr) begin
                            state      <= IDLE;
                            lenError_p <= 1'b1;
                        end else if (wrFire) begin
                            payCnt <= payCnt + len_t'(1);
                            if (payLast) begin
                                state        <= END;
                                payloadEnd_p <= 1'b1;
                            end
                        end
                    end
                    END: begin
                        state    <= DRAIN;
                        drainCnt <= '0;
                    end
                    DRAIN: begin
                        if (ccmpOutLast_p) begin
                            state <= IDLE;
                        end else if (drainCnt == DW'(DRAIN_TIMEOUT - 1)) begin
                            state     <= IDLE;
                            timeout_p <= 1'b1;
                        end else begin
                            drainCnt <= drainCnt + DW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccmp_tx_feeder.sv
// Directed bench for ccmp_tx_feeder with a small CCMP engine model
// that raises ccmpRegFull two cycles after each block-closing write.
module tb_ccmp_tx_feeder;
    import ccmp_pkg::*;

    logic       macCoreClk = 1'b0;
    logic       pRst;
    logic       startFrame_p;
    logic [5:0] hdrLen;
    len_t       payloadLen;
    logic       txError_p;
    logic       ccmp_isIdle;
    logic       ccmpRegFull;
    logic       ccmpOutLast_p;
    logic       initCCMP_p;
    logic       wrCCMPEn_p;
    logic [7:0] plainText;
    logic       payloadEnd_p;
    logic       busy;
    logic       lenError_p;
    logic       timeout_p;

    int vectors = 0;
    int miscompares = 0;

    int nWr, nInit, nEnd, nLenErr, nTo, nHoldWr;
    int orderErr, wrWhileFull, holdMiss, maxBusy;
    int initCyc, endCyc, lastWrCyc, outCyc, idleCyc;
    int toCyc, lenErrCyc, abortCyc;
    logic done;

    ccmp_tx_feeder_if src ();

    ccmp_tx_feeder dut (
        .macCoreClk    (macCoreClk),
        .pRst          (pRst),
        .startFrame_p  (startFrame_p),
        .hdrLen        (hdrLen),
        .payloadLen    (payloadLen),
        .src           (src),
        .txError_p     (txError_p),
        .ccmp_isIdle   (ccmp_isIdle),
        .ccmpRegFull   (ccmpRegFull),
        .ccmpOutLast_p (ccmpOutLast_p),
        .initCCMP_p    (initCCMP_p),
        .wrCCMPEn_p    (wrCCMPEn_p),
        .plainText     (plainText),
        .payloadEnd_p  (payloadEnd_p),
        .busy          (busy),
        .lenError_p    (lenError_p),
        .timeout_p     (timeout_p)
    );

    always #5 macCoreClk = ~macCoreClk;

    function automatic logic [7:0] byteAt(input int k);
        return 8'((k * 13 + 7) & 255);
    endfunction

    // Block-closing byte: 16th of a block, last header or last payload byte.
    function automatic logic isHold(input int k, input int hl, input int pl);
        int j;
        if (k < hl) return ((k % 16) == 15) || (k == hl - 1);
        j = k - hl;
        return ((j % 16) == 15) || (j == pl - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int n);
        startFrame_p  = 1'b0;
        txError_p     = 1'b0;
        ccmpRegFull   = 1'b0;
        ccmpOutLast_p = 1'b0;
        ccmp_isIdle   = 1'b1;
        src.srcValid  = 1'b0;
        src.srcLast   = 1'b0;
        src.srcData   = 8'h00;
        repeat (n) @(posedge macCoreClk);
        #1;
    endtask

    task automatic runFrame(input int hl, input int pl, input int lastAt,
                            input int abortAt, input bit rnd, input int stallAt,
                            input bit giveOut, input int idleLow, input int budget);
        int k;
        int lastIdx;
        int holdAt;
        int stuckAt;
        bit holdPend;
        nWr = 0; nInit = 0; nEnd = 0; nLenErr = 0; nTo = 0; nHoldWr = 0;
        orderErr = 0; wrWhileFull = 0; holdMiss = 0; maxBusy = 0;
        initCyc = -1; endCyc = -1; lastWrCyc = -1; outCyc = -1; idleCyc = -1;
        toCyc = -1; lenErrCyc = -1; abortCyc = -1;
        done = 1'b0;
        k = 0; holdAt = -10; stuckAt = -100; holdPend = 0;
        lastIdx = (pl > 0) ? hl + lastAt : -1;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge macCoreClk);
            #1;
            startFrame_p  = (c == 0);
            hdrLen        = 6'(hl);
            payloadLen    = len_t'(pl);
            ccmp_isIdle   = (c >= idleLow);
            src.srcValid  = (k < hl + pl) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            src.srcData   = byteAt(k);
            src.srcLast   = (k == lastIdx);
            ccmpRegFull   = (c == holdAt + 2) || (c == holdAt + 3) ||
                            (stuckAt >= 0 && c >= stuckAt && c < stuckAt + 20);
            ccmpOutLast_p = giveOut && (endCyc >= 0) && (c == endCyc + 3);
            txError_p     = 1'b0;
            #1;
            if (abortAt >= 0 && k == abortAt && wrCCMPEn_p) begin
                txError_p = 1'b1;
                abortCyc  = c;
            end
            @(negedge macCoreClk);
            if (holdPend && src.srcReady) holdMiss++;
            holdPend = 0;
            if (wrCCMPEn_p) begin
                if (plainText !== byteAt(k)) orderErr++;
                if (ccmpRegFull) wrWhileFull++;
                nWr++;
                lastWrCyc = c;
                if (isHold(k, hl, pl)) begin
                    nHoldWr++;
                    holdAt   = c;
                    holdPend = 1;
                end
                k++;
                if (k == stallAt) stuckAt = c + 1;
            end
            if (initCCMP_p)   begin nInit++;   initCyc = c;   end
            if (payloadEnd_p) begin nEnd++;    endCyc = c;    end
            if (lenError_p)   begin nLenErr++; lenErrCyc = c; end
            if (timeout_p)    begin nTo++;     toCyc = c;     end
            if (ccmpOutLast_p) outCyc = c;
            if (busy) maxBusy = 1;
            if (c >= 1 && !busy) begin
                done    = 1'b1;
                idleCyc = c;
            end
        end
        chk("frame_completes", done, 1);
        quiet(3);
    endtask

    initial begin
        pRst = 1'b1;
        startFrame_p  = 1'b1;
        hdrLen        = 6'd24;
        payloadLen    = len_t'(20);
        txError_p     = 1'b0;
        ccmp_isIdle   = 1'b1;
        ccmpRegFull   = 1'b0;
        ccmpOutLast_p = 1'b0;
        src.srcValid  = 1'b1;
        src.srcLast   = 1'b0;
        src.srcData   = 8'hA5;
        repeat (3) @(posedge macCoreClk);
        @(negedge macCoreClk);
        chk("rst_busy", busy, 0);
        chk("rst_srcReady", src.srcReady, 0);
        chk("rst_wr", wrCCMPEn_p, 0);
        chk("rst_plainText", plainText, 8'h00);
        chk("rst_init", initCCMP_p, 0);
        chk("rst_end", payloadEnd_p, 0);
        chk("rst_lenErr", lenError_p, 0);
        chk("rst_timeout", timeout_p, 0);
        quiet(1);
        pRst = 1'b0;
        quiet(2);

        // Basic 24 + 20 frame
        runFrame(24, 20, 19, -1, 0, -1, 1, 0, 400);
        chk("basic_init_count", nInit, 1);
        chk("basic_init_cycle", initCyc, 2);
        chk("basic_writes", nWr, 44);
        chk("basic_order", orderErr, 0);
        chk("basic_hold_writes", nHoldWr, 4);
        chk("basic_hold_stall", holdMiss, 0);
        chk("basic_no_wr_full", wrWhileFull, 0);
        chk("basic_end_count", nEnd, 1);
        chk("basic_end_cycle", endCyc, lastWrCyc + 1);
        chk("basic_idle_after_outlast", idleCyc, outCyc + 1);
        chk("basic_lenErr", nLenErr, 0);
        chk("basic_timeout", nTo, 0);

        // Header only
        runFrame(30, 0, 0, -1, 0, -1, 1, 0, 300);
        chk("zero_writes", nWr, 30);
        chk("zero_order", orderErr, 0);
        chk("zero_hold_writes", nHoldWr, 2);
        chk("zero_end_count", nEnd, 1);
        chk("zero_end_cycle", endCyc, lastWrCyc + 1);
        chk("zero_idle", idleCyc, outCyc + 1);

        // Early srcLast on payload byte 5 of 10
        runFrame(24, 10, 4, -1, 0, -1, 1, 0, 300);
        chk("early_last_lenErr", nLenErr, 1);
        chk("early_last_writes", nWr, 29);
        chk("early_last_err_cycle", lenErrCyc, lastWrCyc + 1);
        chk("early_last_idle", idleCyc, lastWrCyc + 1);
        chk("early_last_no_end", nEnd, 0);

        // Oversized header
        runFrame(40, 8, 7, -1, 0, -1, 1, 0, 50);
        chk("hdr40_lenErr", nLenErr, 1);
        chk("hdr40_err_cycle", lenErrCyc, 1);
        chk("hdr40_busy", maxBusy, 0);
        chk("hdr40_init", nInit, 0);

        // Abort on the final payload write
        runFrame(24, 20, 19, 43, 0, -1, 1, 0, 400);
        chk("abort_seen", abortCyc >= 0, 1);
        chk("abort_writes", nWr, 43);
        chk("abort_no_end", nEnd, 0);
        chk("abort_idle", idleCyc, abortCyc + 1);

        // Engine busy for cycles 1..5 of the wait
        runFrame(24, 4, 3, -1, 0, -1, 1, 6, 300);
        chk("wait_init_cycle", initCyc, 7);
        chk("wait_init_count", nInit, 1);
        chk("wait_writes", nWr, 28);
        chk("wait_end", nEnd, 1);

        // Random valid, register stuck full for 20 cycles
        runFrame(24, 20, 19, -1, 1, 5, 1, 0, 800);
        chk("bp_writes", nWr, 44);
        chk("bp_order", orderErr, 0);
        chk("bp_no_wr_full", wrWhileFull, 0);
        chk("bp_hold_stall", holdMiss, 0);
        chk("bp_end", nEnd, 1);

        // No last output byte from the engine
        runFrame(24, 4, 3, -1, 0, -1, 0, 0, 1500);
        chk("to_count", nTo, 1);
        chk("to_cycle", toCyc, endCyc + 1024);
        chk("to_idle", idleCyc, toCyc);
        chk("to_end", nEnd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
